// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch + data load/store) sharing one
// single-port memory with a fixed read latency; at most one read in flight.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch requester
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  // data requester
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  // memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);
  localparam logic [1:0] HIST_MAX = 2'd2;

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;   // 1 = data owns the outstanding read
  logic [1:0]  hist_q, hist_d;     // consecutive data grants, saturating

  logic        grant_ok_s;
  logic        rvalid_fire_s;
  logic        sel_data_s;
  logic        sel_fetch_s;

  // Both requesters see the raw memory data; rvalid alone qualifies it.
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  // State, latency counter, read owner and data-grant history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      owner_q <= 1'b0;
      hist_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      hist_q  <= hist_d;
    end
  end

  // Arbitration, next-state and memory-port drive.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    hist_d        = hist_q;
    grant_ok_s    = 1'b0;
    rvalid_fire_s = 1'b0;
    if_gnt        = 1'b0;
    d_gnt         = 1'b0;
    if_rvalid     = 1'b0;
    d_rvalid      = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_be        = '0;

    case (state_q)
      IDLE: begin
        grant_ok_s = 1'b1;
      end
      RD_WAIT: begin
        if (cnt_q <= 3'd1) begin
          // final latency cycle: deliver data and allow a back-to-back grant
          rvalid_fire_s = 1'b1;
          grant_ok_s    = 1'b1;
          state_d       = IDLE;
          cnt_d         = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // Fetch overrides data only after two data grants in a row.
    sel_data_s  = d_req && !(if_req && (hist_q == HIST_MAX));
    sel_fetch_s = if_req && !sel_data_s;

    if (grant_ok_s && sel_data_s) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      hist_d    = (hist_q == HIST_MAX) ? HIST_MAX : (hist_q + 2'd1);
      if (d_we) begin
        mem_be = d_be;
      end else begin
        mem_be  = {BE_W{1'b1}};
        state_d = RD_WAIT;
        cnt_d   = LAT_INIT;
        owner_d = 1'b1;
      end
    end else if (grant_ok_s && sel_fetch_s) begin
      if_gnt   = 1'b1;
      mem_en   = 1'b1;
      mem_addr = if_addr;
      mem_be   = {BE_W{1'b1}};
      hist_d   = 2'd0;
      state_d  = RD_WAIT;
      cnt_d    = LAT_INIT;
      owner_d  = 1'b0;
    end else begin
      hist_d = hist_q;
    end

    if (rvalid_fire_s) begin
      if_rvalid = !owner_q;
      d_rvalid  = owner_q;
    end else begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
    end

    // Strobes are forced quiet while reset is held.
    if (reset) begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
    end else begin
      mem_en = mem_en;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance 1 (MEM_LAT=2) carries the functional vectors,
// instances 0 and 2 (MEM_LAT=1, 4) carry the latency sweeps.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req   [0:2];
  logic [8:0]  if_addr  [0:2];
  logic        if_gnt   [0:2];
  logic        if_rvalid[0:2];
  logic [31:0] if_rdata [0:2];
  logic        d_req    [0:2];
  logic        d_we     [0:2];
  logic [8:0]  d_addr   [0:2];
  logic [31:0] d_wdata  [0:2];
  logic [3:0]  d_be     [0:2];
  logic        d_gnt    [0:2];
  logic        d_rvalid [0:2];
  logic [31:0] d_rdata  [0:2];
  logic        mem_en   [0:2];
  logic        mem_we   [0:2];
  logic [8:0]  mem_addr [0:2];
  logic [31:0] mem_wdata[0:2];
  logic [3:0]  mem_be   [0:2];
  logic [31:0] mem_rdata[0:2];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [8:0] pipe [0:3];

    // Memory model: word at address a reads as 0xA500_0000 | a, LAT cycles later.
    always_ff @(posedge clk) begin
      pipe[0] <= mem_addr[g];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = 32'hA500_0000 | {23'd0, pipe[LAT-1]};

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_gnt   (if_gnt[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata (if_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_be     (d_be[g]),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_be   (mem_be[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input int idx, input int lat);
    if_req[idx]  = 1'b1;
    if_addr[idx] = 9'h030;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val("sweep_gnt", {63'd0, if_gnt[idx]}, 64'd1);
      check_val("sweep_addr", {55'd0, mem_addr[idx]}, 64'h30 + 64'(k));
      tick();
      if (k == 2) if_req[idx] = 1'b0;
      else        if_addr[idx] = 9'h031 + 9'(k);
      #1;
      for (int j = 1; j < lat; j++) begin
        check_val("sweep_wait_gnt", {63'd0, if_gnt[idx]}, 64'd0);
        check_val("sweep_wait_rv", {63'd0, if_rvalid[idx]}, 64'd0);
        tick();
        #1;
      end
      check_val("sweep_rvalid", {63'd0, if_rvalid[idx]}, 64'd1);
      check_val("sweep_rdata", {32'd0, if_rdata[idx]}, 64'hA500_0030 + 64'(k));
    end
    check_val("sweep_end_gnt", {63'd0, if_gnt[idx]}, 64'd0);
    tick();
  endtask

  logic exp_d [0:5];
  logic prev_d;

  initial begin
    for (int i = 0; i < 3; i++) begin
      if_req[i] = 1'b0; if_addr[i] = 9'd0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 9'd0;
      d_wdata[i] = 32'd0; d_be[i] = 4'd0;
    end
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b0;
    exp_d[3] = 1'b1; exp_d[4] = 1'b1; exp_d[5] = 1'b0;

    // reset: requests present but everything quiet
    tick();
    if_req[1] = 1'b1; d_req[1] = 1'b1; d_we[1] = 1'b1;
    #1;
    check_val("rst_if_gnt", {63'd0, if_gnt[1]}, 64'd0);
    check_val("rst_d_gnt", {63'd0, d_gnt[1]}, 64'd0);
    check_val("rst_mem_en", {63'd0, mem_en[1]}, 64'd0);
    check_val("rst_mem_we", {63'd0, mem_we[1]}, 64'd0);
    tick();
    reset = 1'b0; if_req[1] = 1'b0; d_req[1] = 1'b0; d_we[1] = 1'b0;

    // single fetch, addr 4
    if_req[1] = 1'b1; if_addr[1] = 9'h004;
    #1;
    check_val("f1_gnt", {63'd0, if_gnt[1]}, 64'd1);
    check_val("f1_mem_en", {63'd0, mem_en[1]}, 64'd1);
    check_val("f1_mem_addr", {55'd0, mem_addr[1]}, 64'h4);
    check_val("f1_mem_we", {63'd0, mem_we[1]}, 64'd0);
    check_val("f1_mem_be", {60'd0, mem_be[1]}, 64'hF);
    tick();
    if_req[1] = 1'b0;
    #1;
    check_val("f1_wait_en", {63'd0, mem_en[1]}, 64'd0);
    check_val("f1_wait_rv", {63'd0, if_rvalid[1]}, 64'd0);
    tick();
    #1;
    check_val("f1_rvalid", {63'd0, if_rvalid[1]}, 64'd1);
    check_val("f1_rdata", {32'd0, if_rdata[1]}, 64'hA500_0004);
    check_val("f1_d_rvalid", {63'd0, d_rvalid[1]}, 64'd0);
    tick();
    #1;
    check_val("f1_rv_done", {63'd0, if_rvalid[1]}, 64'd0);

    // store, then a fetch granted the very next cycle
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 9'h020;
    d_wdata[1] = 32'hDEAD_BEEF; d_be[1] = 4'b0011;
    #1;
    check_val("st_gnt", {63'd0, d_gnt[1]}, 64'd1);
    check_val("st_mem_we", {63'd0, mem_we[1]}, 64'd1);
    check_val("st_mem_be", {60'd0, mem_be[1]}, 64'h3);
    check_val("st_mem_addr", {55'd0, mem_addr[1]}, 64'h20);
    check_val("st_wdata", {32'd0, mem_wdata[1]}, 64'hDEAD_BEEF);
    tick();
    d_req[1] = 1'b0; d_we[1] = 1'b0;
    if_req[1] = 1'b1; if_addr[1] = 9'h005;
    #1;
    check_val("st_no_rvalid", {63'd0, d_rvalid[1]}, 64'd0);
    check_val("st_next_gnt", {63'd0, if_gnt[1]}, 64'd1);
    tick();
    if_req[1] = 1'b0;
    tick();
    #1;
    check_val("st_f_rdata", {32'd0, if_rdata[1]}, 64'hA500_0005);
    check_val("st_f_rvalid", {63'd0, if_rvalid[1]}, 64'd1);
    tick();

    // both held: D, D, F, D, D, F with rvalid to the right owner
    if_req[1] = 1'b1; if_addr[1] = 9'h008;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 9'h010;
    #1;
    prev_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_val("arb_d_gnt", {63'd0, d_gnt[1]}, {63'd0, exp_d[k]});
      check_val("arb_if_gnt", {63'd0, if_gnt[1]}, {63'd0, !exp_d[k]});
      if (k > 0) begin
        check_val("arb_d_rv", {63'd0, d_rvalid[1]}, {63'd0, prev_d});
        check_val("arb_if_rv", {63'd0, if_rvalid[1]}, {63'd0, !prev_d});
      end
      prev_d = exp_d[k];
      tick();
      check_val("arb_wait_gnt", {63'd0, d_gnt[1] | if_gnt[1]}, 64'd0);
      tick();
    end
    if_req[1] = 1'b0; d_req[1] = 1'b0;
    #1;
    check_val("arb_last_rv", {63'd0, if_rvalid[1]}, 64'd1);
    check_val("arb_last_rdata", {32'd0, if_rdata[1]}, 64'hA500_0008);
    check_val("arb_last_nogt", {63'd0, d_gnt[1] | if_gnt[1]}, 64'd0);
    tick();

    // two stores push history to 2, then a load; reset during RD_WAIT
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 9'h021; d_be[1] = 4'hF;
    tick(); tick();
    d_we[1] = 1'b0; d_addr[1] = 9'h011;
    #1;
    check_val("rw_load_gnt", {63'd0, d_gnt[1]}, 64'd1);
    tick();
    d_req[1] = 1'b0; reset = 1'b1;
    #1;
    check_val("rw_rst_rv", {63'd0, d_rvalid[1]}, 64'd0);
    tick();
    reset = 1'b0;
    if_req[1] = 1'b1; if_addr[1] = 9'h00C;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 9'h012;
    #1;
    check_val("rw_no_stale_rv", {63'd0, d_rvalid[1]}, 64'd0);
    check_val("rw_hist_clr_d", {63'd0, d_gnt[1]}, 64'd1);
    check_val("rw_hist_clr_f", {63'd0, if_gnt[1]}, 64'd0);
    tick();
    d_req[1] = 1'b0;
    tick();
    #1;
    check_val("rw_d_rv", {63'd0, d_rvalid[1]}, 64'd1);
    check_val("rw_d_rdata", {32'd0, d_rdata[1]}, 64'hA500_0012);
    check_val("rw_pend_f_gnt", {63'd0, if_gnt[1]}, 64'd1);
    tick();
    if_req[1] = 1'b0;
    tick();
    #1;
    check_val("rw_f_rv", {63'd0, if_rvalid[1]}, 64'd1);
    check_val("rw_f_rdata", {32'd0, if_rdata[1]}, 64'hA500_000C);
    tick();

    // latency sweeps
    run_sweep(0, 1);
    run_sweep(2, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 9, word-address width; DATA_W, 32, data width; MEM_LAT, 2, memory read latency in cycles (legal 1..4).
REQ-002 SHALL have ports (name  direction  width  meaning): clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have fetch ports: if_req  in  1  fetch read request; if_addr  in  ADDR_W  fetch address; if_gnt  out  1  request accepted; if_rvalid  out  1  fetch data valid; if_rdata  out  DATA_W  fetch data.
REQ-004 SHALL have data ports: d_req  in  1  load/store request; d_we  in  1  1=store; d_addr  in  ADDR_W  address; d_wdata  in  DATA_W  store data; d_be  in  DATA_W/8  byte enables; d_gnt  out  1  accepted; d_rvalid  out  1  load data valid; d_rdata  out  DATA_W  load data.
REQ-005 SHALL have memory ports: mem_en  out  1  access strobe; mem_we  out  1  write; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8; mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en read.

Function
REQ-006 SHALL share one single-port memory between fetch and data requesters, at most one read outstanding.
REQ-007 SHALL implement states IDLE, RD_WAIT; grant is combinational from state and requests, all other state registered.
REQ-008 IDLE: if any request, SHALL grant exactly one (gnt high one cycle, mem_en high same cycle, mem_* driven from winner's inputs).
REQ-009 Priority: data over fetch, except fetch SHALL win when if_req high and the previous two grants both went to data (starvation bound: fetch waits at most 2 data grants).
REQ-010 Store grant: mem_we=1, mem_be=d_be; state SHALL stay IDLE; no rvalid; next grant allowed next cycle.
REQ-011 Read grant: mem_we=0, mem_be=all ones; SHALL enter RD_WAIT, load latency counter with MEM_LAT, record owner (fetch/data).
REQ-012 RD_WAIT: counter SHALL decrement each cycle; no grant issued while counter >1; mem_en=0.
REQ-013 When counter==1 (final cycle): SHALL pulse owner's rvalid one cycle with rdata=mem_rdata; other rvalid stays 0.
REQ-014 In the rvalid cycle, a pending request SHALL be granted (back-to-back); otherwise return to IDLE.
REQ-015 Requesters SHALL hold req/addr/data stable until gnt; arbiter SHALL ignore deasserted requests (no grant to withdrawn req).
REQ-016 if_rdata/d_rdata SHALL both mirror mem_rdata; only rvalid qualifies.
REQ-017 Back-to-back reads SHALL sustain one read per MEM_LAT cycles; stores interleave at one per cycle while IDLE.
REQ-018 Simultaneous if_req and d_req in IDLE with data-grant history <2: data wins, fetch held pending, not dropped.
REQ-019 Data-grant history counter SHALL saturate at 2 and clear on any fetch grant.

Reset
REQ-020 On reset high at a clk edge: state=IDLE, counter=0, owner=fetch, history=0; in-flight read SHALL be discarded (no rvalid after reset).
REQ-021 During reset, all gnt, rvalid, mem_en, mem_we SHALL be 0; mem_addr/mem_wdata/mem_be are don't-care.

Verification
REQ-022 MEM_LAT=2, single if_req addr 0x04 -> if_gnt cycle 0, mem_en=1 addr 0x04, if_rvalid cycle 2 with rdata=mem word 4.
REQ-023 if_req and d_req (load 0x10) held continuously -> grant order D, D, F, D, D, F; each rvalid to correct owner.
REQ-024 d_req store addr 0x20 wdata 0xDEADBEEF be 0011 -> d_gnt, mem_we=1, mem_be=0011 same cycle, no d_rvalid, next request granted next cycle.
REQ-025 Read issued, reset asserted in RD_WAIT -> no rvalid; after reset, IDLE, history=0, new if_req granted immediately.
REQ-026 MEM_LAT=1 and MEM_LAT=4 sweeps with back-to-back fetches -> rvalid exactly MEM_LAT cycles after each gnt, one read per MEM_LAT cycles.
